// File: rtl/pc_fetch_pkg.sv
// Shared miniRV definitions: next-PC select encodings common to the decoder
// and the fetch stage, plus the default reset PC.
package pc_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [3:0] NPC_PC4 = 4'd0;
  localparam logic [3:0] NPC_B   = 4'd1;
  localparam logic [3:0] NPC_JMP = 4'd2;
  localparam logic [3:0] NPC_ALU = 4'd3;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, conditional branch, PC-relative
// jump, or register-indirect jump with bit 0 cleared.
module npc_calc
  import pc_fetch_pkg::*;
(
  input  logic [31:0] inst_pc,
  input  logic [3:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] alu_c,
  input  logic [31:0] ext_imm,
  output logic [31:0] npc
);

  logic [31:0] pc4;
  logic [31:0] pc_imm;

  assign pc4    = inst_pc + 32'd4;
  assign pc_imm = inst_pc + ext_imm;

  always_comb begin
    npc = pc4;
    case (npc_op)
      NPC_B:   npc = br_taken ? pc_imm : pc4;
      NPC_JMP: npc = pc_imm;
      NPC_ALU: npc = alu_c & ~32'h1;
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the PC, issues one memory request per
// instruction, holds the fetched word for decode and advances on consumption.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic [3:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] alu_c,
  input  logic [31:0] ext_imm,
  output logic        fetch_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic [31:0] inst_cnt_reg;
  logic [31:0] npc;
  logic        consume;
  logic        capture;

  npc_calc u_npc_calc (
    .inst_pc  (inst_pc_reg),
    .npc_op   (npc_op),
    .br_taken (br_taken),
    .alu_c    (alu_c),
    .ext_imm  (ext_imm),
    .npc      (npc)
  );

  // Handshake qualifiers: rvalid only matters in WAIT, ready only in HOLD.
  assign capture = (state_reg == ST_WAIT) && imem_rvalid;
  assign consume = (state_reg == ST_HOLD) && inst_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: if (imem_rvalid) state_next = ST_HOLD;
      ST_HOLD: if (inst_ready) state_next = is_misaligned(npc) ? ST_ERR : ST_REQ;
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= RESET_PC;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= RESET_PC;
      inst_cnt_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        inst_reg    <= imem_rdata;
        inst_pc_reg <= pc_reg;
      end
      if (consume) begin
        inst_cnt_reg <= inst_cnt_reg + 32'd1;
        // A misaligned target freezes the PC at the offending instruction.
        if (!is_misaligned(npc)) pc_reg <= npc;
      end
    end
  end

  assign imem_req   = (state_reg == ST_REQ);
  assign imem_addr  = pc_reg;
  assign inst_valid = (state_reg == ST_HOLD);
  assign inst       = inst_reg;
  assign inst_pc    = inst_pc_reg;
  assign inst_pc4   = inst_pc_reg + 32'd4;
  assign fetch_err  = (state_reg == ST_ERR);
  assign inst_cnt   = inst_cnt_reg;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed and randomized checks of pc_fetch against a transaction-level
// model of the fetch loop and next-PC rules.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;
  logic [3:0]  npc_op;
  logic        br_taken;
  logic [31:0] alu_c;
  logic [31:0] ext_imm;
  logic        fetch_err;
  logic [31:0] inst_cnt;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pc4    (inst_pc4),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .alu_c       (alu_c),
    .ext_imm     (ext_imm),
    .fetch_err   (fetch_err),
    .inst_cnt    (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural next-PC rule, stated directly in terms of the ISA semantics.
  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [3:0] op,
                                          input logic br, input logic [31:0] alu,
                                          input logic [31:0] imm);
    logic [32:0] sum;
    if (op == NPC_JMP || (op == NPC_B && br)) begin
      sum = {1'b0, pc} + {1'b0, imm};
      return sum[31:0];
    end
    if (op == NPC_ALU) return {alu[31:1], 1'b0};
    sum = {1'b0, pc} + 33'd4;
    return sum[31:0];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   imem_req,   0);
    chk({tag, "_addr"},  imem_addr,  32'h0);
    chk({tag, "_valid"}, inst_valid, 0);
    chk({tag, "_inst"},  inst,       32'h0);
    chk({tag, "_pc"},    inst_pc,    32'h0);
    chk({tag, "_pc4"},   inst_pc4,   32'h4);
    chk({tag, "_err"},   fetch_err,  0);
    chk({tag, "_cnt"},   inst_cnt,   32'h0);
  endtask

  task automatic randomize_ignored();
    npc_op   = 4'($urandom);
    br_taken = 1'($urandom);
    alu_c    = $urandom;
    ext_imm  = $urandom;
  endtask

  // One fetch transaction, entered and left at the sample point of a REQ cycle
  // (or of the ERR cycle when the target is misaligned).
  task automatic do_instr(input int lat, input int stall, input logic spurious,
                          input logic [3:0] op, input logic br,
                          input logic [31:0] alu, input logic [31:0] imm);
    logic [31:0] data;
    logic [31:0] npc;
    data = $urandom;
    chk("req", imem_req, 1);
    chk("req_addr", imem_addr, exp_pc);
    chk("req_valid", inst_valid, 0);
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    inst_ready  = 1'($urandom);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      chk("wait_req", imem_req, 0);
      chk("wait_valid", inst_valid, 0);
      imem_rvalid = (i == lat);
      imem_rdata  = (i == lat) ? data : $urandom;
      inst_ready  = 1'($urandom);
      randomize_ignored();
    end
    @(posedge clk); #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    inst_ready  = 1'b0;
    chk("hold_valid", inst_valid, 1);
    chk("hold_inst", inst, data);
    chk("hold_pc", inst_pc, exp_pc);
    chk("hold_pc4", inst_pc4, exp_pc + 32'd4);
    chk("hold_cnt", inst_cnt, exp_cnt);
    for (int i = 0; i < stall; i++) begin
      randomize_ignored();
      if (spurious && i == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      imem_rvalid = 1'b0;
      chk("stall_valid", inst_valid, 1);
      chk("stall_inst", inst, data);
      chk("stall_req", imem_req, 0);
    end
    npc_op     = op;
    br_taken   = br;
    alu_c      = alu;
    ext_imm    = imm;
    inst_ready = 1'b1;
    npc = ref_npc(exp_pc, op, br, alu, imm);
    @(posedge clk); #1;
    inst_ready = 1'b0;
    randomize_ignored();
    exp_cnt = exp_cnt + 32'd1;
    chk("cnt", inst_cnt, exp_cnt);
    if (npc[1:0] != 2'b00) begin
      chk("err_flag", fetch_err, 1);
      chk("err_valid", inst_valid, 0);
      chk("err_req", imem_req, 0);
      chk("err_addr", imem_addr, exp_pc);
    end else begin
      exp_pc = npc;
    end
    $display("instr pc=%h op=%0d lat=%0d stall=%0d npc=%h cnt=%0d", inst_pc, op, lat, stall, npc, exp_cnt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_pc      = 32'h0;
    exp_cnt     = 32'h0;
    rst_n       = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;
    npc_op      = NPC_PC4;
    br_taken    = 1'b0;
    alu_c       = 32'h0;
    ext_imm     = 32'h0;

    #2 rst_n = 1'b0;
    #1 chk_reset("por");
    repeat (3) @(posedge clk);
    #1 chk_reset("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential fetch, latency 1, ready immediately.
    for (int i = 0; i < 4; i++) do_instr(1, 0, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    chk("seq_pc", exp_pc, 32'h10);

    // Branches from 0x10.
    do_instr(1, 0, 1'b0, NPC_B, 1'b1, 32'h0, 32'hFFFF_FFF8);
    chk("br_taken_addr", imem_addr, 32'h08);
    do_instr(1, 0, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    do_instr(1, 0, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    do_instr(1, 0, 1'b0, NPC_B, 1'b0, 32'h0, 32'hFFFF_FFF8);
    chk("br_not_taken_addr", imem_addr, 32'h14);

    // JAL / JALR from 0x20.
    do_instr(1, 0, 1'b0, NPC_JMP, 1'b0, 32'h0, 32'h0000_000C);
    do_instr(1, 0, 1'b0, NPC_JMP, 1'b0, 32'h0, 32'h0000_0100);
    chk("jal_addr", imem_addr, 32'h120);
    do_instr(1, 0, 1'b0, NPC_JMP, 1'b0, 32'h0, 32'hFFFF_FF00);
    do_instr(1, 0, 1'b0, NPC_ALU, 1'b0, 32'h201, 32'h0);
    chk("jalr_addr", imem_addr, 32'h200);

    // Slow memory and a stalled consumer with a stray response.
    do_instr(4, 5, 1'b1, NPC_PC4, 1'b0, 32'h0, 32'h0);
    chk("stall_next_addr", imem_addr, 32'h204);

    // Randomized traffic with aligned targets.
    for (int n = 0; n < 24; n++) begin
      do_instr($urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom),
               4'($urandom), 1'($urandom), $urandom & ~32'h2, $urandom & ~32'h3);
    end

    // Misaligned jump target.
    do_instr(2, 0, 1'b0, NPC_JMP, 1'b0, 32'h0, 32'h102 - exp_pc);
    for (int i = 0; i < 5; i++) begin
      imem_rvalid = 1'($urandom);
      inst_ready  = 1'($urandom);
      randomize_ignored();
      @(posedge clk); #1;
      chk("err_stuck", fetch_err, 1);
      chk("err_noreq", imem_req, 0);
      chk("err_novalid", inst_valid, 0);
      chk("err_cnt", inst_cnt, exp_cnt);
    end
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("err_rst");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    exp_pc  = 32'h0;
    exp_cnt = 32'h0;
    @(posedge clk); #1;
    do_instr(1, 0, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    do_instr(2, 1, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    chk("restart_addr", imem_addr, 32'h8);

    // Reset during WAIT, then a late response while coming out of reset.
    @(posedge clk); #1;
    chk("mid_wait_req", imem_req, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(posedge clk); #1;
    chk_reset("mid_rst_edge");
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    exp_pc      = 32'h0;
    exp_cnt     = 32'h0;
    @(posedge clk); #1;
    chk("late_inst", inst, 32'h0);
    chk("late_cnt", inst_cnt, 32'h0);
    do_instr(2, 0, 1'b0, NPC_PC4, 1'b0, 32'h0, 32'h0);
    chk("post_rst_addr", imem_addr, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
